// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM states and GF(2^8) helpers for the AES-128 inverse cipher
package aes_pkg;
  localparam int NR = 10;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} dec_state_e;
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic int bidx(input int r, input int c);
    return (r & 3) + 4 * (c & 3);
  endfunction
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    return s[127 - 8 * i -: 8];
  endfunction
endpackage

// File: rtl/aes_decrypt_core_inverse_round.sv
// decrypt_inverse_round: one combinational AES inverse round, InvMixColumns skipped on the last round
module decrypt_inverse_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] result
);
  logic [127:0] sub, ark, mix;
  // row r rotates right by r columns, then every byte goes through the inverse S-box
  always_comb begin
    sub = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sub[127 - 8 * bidx(r, c) -: 8] = inv_sbox(get_byte(state, bidx(r, c - r)));
  end
  assign ark = sub ^ rk;
  // each output byte is the circulant {0e,0b,0d,09} product of its column
  always_comb begin
    mix = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        mix[127 - 8 * bidx(r, c) -: 8] = gf_mul(get_byte(ark, bidx(r, c)), 8'h0e) ^
                                          gf_mul(get_byte(ark, bidx(r + 1, c)), 8'h0b) ^
                                          gf_mul(get_byte(ark, bidx(r + 2, c)), 8'h0d) ^
                                          gf_mul(get_byte(ark, bidx(r + 3, c)), 8'h09);
  end
  assign result = last_round ? ark : mix;
endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one round per clock; AES_DEC_ABORT_EN adds an abort input
module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  dec_state_e st, st_nxt;
  logic [3:0] cnt;
  logic [127:0] state_reg, rnd_out;
  logic accept, kill;
`ifdef AES_DEC_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign out_data = state_reg;
  assign accept = in_valid && in_ready && !kill;
  assign rk_idx = st == ROUND ? cnt : st == FINAL ? 4'd0 : 4'(NR);
  decrypt_inverse_round u_round (
    .state(state_reg),
    .rk(rk),
    .last_round(st == FINAL),
    .result(rnd_out)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_nxt;
  // next state; abort wins over everything, including an accept in IDLE
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    st_nxt = accept ? ROUND : IDLE;
      ROUND:   st_nxt = cnt == 4'd1 ? FINAL : ROUND;
      FINAL:   st_nxt = DONE;
      DONE:    st_nxt = out_ready ? IDLE : DONE;
      default: st_nxt = IDLE;
    endcase
    if (kill) st_nxt = IDLE;
  end
  // datapath: initial AddRoundKey on accept, then one inverse round per cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      state_reg <= '0;
    end else if (accept) begin
      cnt <= 4'(NR - 1);
      state_reg <= in_data ^ rk;
    end else if (st == ROUND || st == FINAL) begin
      cnt <= st == ROUND ? cnt - 4'd1 : cnt;
      state_reg <= rnd_out;
    end
endmodule
